// File: rtl/bpa_rr_scheduler.sv
// Round-robin scheduler sharing one serial OR-fold engine between NREQ requesters.
// Optional early exit on an all-ones accumulator: define BPA_SCHED_EARLY_EXIT_EN.

module bpa_req_lane #(
  parameter int W      = 10,
  parameter int NSLICE = 48,
  parameter int IXW    = 6
) (
  input  logic                  sel_i,
  input  logic [NSLICE*W-1:0]   vec_i,
  input  logic [IXW-1:0]        idx_i,
  output logic [W-1:0]          slice_o
);
  // Only the granted lane contributes, so the fold reduces to an OR across lanes.
  assign slice_o = sel_i ? vec_i[idx_i*W +: W] : '0;
endmodule

module bpa_rr_scheduler #(
  parameter int NREQ   = 4,
  parameter int W      = 10,
  parameter int NSLICE = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*NSLICE*W-1:0]  req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [W-1:0]              res_data,
  output logic [$clog2(NREQ)-1:0]   res_id
);
  localparam int IDW = $clog2(NREQ);
  localparam int IXW = $clog2(NSLICE);
  localparam int VW  = NSLICE*W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]      res_id_q, res_id_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IXW-1:0]      idx_q, idx_d;
  logic [W-1:0]        acc_q, acc_d;

  logic [NREQ-1:0][W-1:0] lane_slice;
  logic [W-1:0]           cur_slice;
  logic [W-1:0]           acc_nxt;
  logic                   pick_vld;
  logic [IDW-1:0]         pick_id;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    bpa_req_lane #(.W(W), .NSLICE(NSLICE), .IXW(IXW)) u_lane (
      .sel_i   (gnt_q[g]),
      .vec_i   (req_data[g*VW +: VW]),
      .idx_i   (idx_q),
      .slice_o (lane_slice[g])
    );
  end

  always_comb begin
    cur_slice = '0;
    for (int i = 0; i < NREQ; i++) cur_slice = cur_slice | lane_slice[i];
  end

  assign acc_nxt = acc_q | cur_slice;

  // First set request at or above rr_ptr, wrapping.
  always_comb begin
    int c;
    c        = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(rr_ptr_q) + k) % NREQ;
      if (!pick_vld && req[c]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(c);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    res_id_d = res_id_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          res_id_d       = pick_id;
          acc_d          = '0;
          idx_d          = '0;
          state_d        = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_nxt;
        idx_d = idx_q + 1'b1;
        if (idx_q == IXW'(NSLICE-1)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
`ifdef BPA_SCHED_EARLY_EXIT_EN
        if (&acc_nxt) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (res_ready) begin
          gnt_d    = '0;
          rr_ptr_d = (res_id_q == IDW'(NREQ-1)) ? '0 : res_id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      res_id_q <= '0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      res_id_q <= res_id_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_valid ? acc_q : '0;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_bpa_rr_scheduler.sv
// Self-checking bench for bpa_rr_scheduler against a transaction-level reference model.
module tb_bpa_rr_scheduler;
  localparam int NREQ   = 4;
  localparam int W      = 10;
  localparam int NSLICE = 48;
  localparam int IDW    = $clog2(NREQ);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREQ-1:0]           req;
  logic [NREQ*NSLICE*W-1:0]  req_data;
  logic [NREQ-1:0]           gnt;
  logic                      busy;
  logic                      res_valid;
  logic                      res_ready;
  logic [W-1:0]              res_data;
  logic [IDW-1:0]            res_id;

  int n_cmp = 0;
  int n_err = 0;
  int ptr   = 0;

  bpa_rr_scheduler #(.NREQ(NREQ), .W(W), .NSLICE(NSLICE)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_slice(input int r, input int k, input logic [W-1:0] v);
    req_data[(r*NSLICE+k)*W +: W] = v;
  endtask

  function automatic logic [W-1:0] get_slice(input int r, input int k);
    return req_data[(r*NSLICE+k)*W +: W];
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Model: rotating priority starting at ptr.
  function automatic int pick(input logic [NREQ-1:0] rv);
    for (int k = 0; k < NREQ; k++)
      if (rv[(ptr+k)%NREQ]) return (ptr+k)%NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] fold(input int r);
    logic [W-1:0] a;
    a = '0;
    for (int k = 0; k < NSLICE; k++) a = a | get_slice(r, k);
    return a;
  endfunction

  function automatic int exp_lat(input int r);
`ifdef BPA_SCHED_EARLY_EXIT_EN
    logic [W-1:0] a;
    a = '0;
    for (int k = 0; k < NSLICE; k++) begin
      a = a | get_slice(r, k);
      if (&a) return k + 2;
    end
`endif
    return NSLICE + 1;
  endfunction

  task automatic rand_data();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < NSLICE; k++) begin
        logic [W-1:0] v;
        v = '0;
        if ($urandom_range(0, 7) == 0) v[$urandom_range(0, W-1)] = 1'b1;
        if ($urandom_range(0, 60) == 0) v = W'($urandom);
        set_slice(r, k, v);
      end
  endtask

  task automatic do_reset();
    req = '0;
    res_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
  endtask

  // mode: 0 = hold req, 1 = drop req after grant, 2 = raise all req after grant
  task automatic run_txn(input logic [NREQ-1:0] rv, input int hold, input int mode);
    int id, lat, n;
    logic [W-1:0] ed;
    id  = pick(rv);
    ed  = fold(id);
    lat = exp_lat(id);
    req = rv;
    @(posedge clk); #1;
    chk("grant", 32'(gnt), 32'(oh(id)));
    chk("busy_accum", 32'(busy), 1);
    if (mode == 1) req = '0;
    if (mode == 2) req = '1;
    n = 1;
    while (!res_valid && n < 300) begin
      res_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    res_ready = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("res_data", 32'(res_data), 32'(ed));
    chk("res_id", 32'(res_id), 32'(id));
    chk("gnt_done", 32'(gnt), 32'(oh(id)));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_data", 32'(res_data), 32'(ed));
      chk("hold_id", 32'(res_id), 32'(id));
      chk("hold_gnt", 32'(gnt), 32'(oh(id)));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("accept_valid", 32'(res_valid), 0);
    chk("accept_gnt", 32'(gnt), 0);
    chk("accept_busy", 32'(busy), 0);
    ptr = (id + 1) % NREQ;
  endtask

  initial begin
    req = '0;
    req_data = '0;
    res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_id", 32'(res_id), 0);
    rst = 1'b0;

    // Single requester, only the last slice set.
    req_data = '0;
    set_slice(0, NSLICE-1, 10'h001);
    run_txn(4'b0001, 0, 0);

    // Round robin from reset with wrap.
    do_reset();
    rand_data();
    run_txn(4'b0101, 0, 0);
    run_txn(4'b0101, 0, 0);
    run_txn(4'b0101, 0, 0);

    // Stall in DONE for 5 cycles with competing requests raised.
    rand_data();
    run_txn(4'b0010, 5, 2);

    // Reset in the middle of an accumulation.
    do_reset();
    rand_data();
    req = 4'b0001;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(res_valid), 0);
    chk("midrst_data", 32'(res_data), 0);
    chk("midrst_id", 32'(res_id), 0);
    rst = 1'b0;
    ptr = 0;
    @(posedge clk); #1;
    run_txn(4'b0001, 0, 0);

    // All-ones first slice.
    do_reset();
    rand_data();
    set_slice(0, 0, 10'h3FF);
    run_txn(4'b0001, 0, 0);

    // All requesters continuously.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      rand_data();
      run_txn(4'b1111, 0, 0);
    end

    // Random traffic.
    for (int t = 0; t < 20; t++) begin
      logic [NREQ-1:0] rv;
      rand_data();
      rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_txn(rv, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
